// File: rtl/ula_arb_if.sv
// Request/ALU/response bundle for the two-requester shared-ALU arbiter.
// slave is the arbiter side, master is the environment (requesters, ALU, consumer).
interface ula_arb_if #(parameter int W = 8);
    logic         req0_valid, req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [2:0]   alu_sel;
    logic         alu_cout;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_cout, rsp_zero, rsp_err;
    logic         busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_cout,
        output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_cout,
        input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/ula_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// one operation in flight, IDLE -> EXEC -> RESP.
module ula_arb #(
    parameter int W = 8
) (
    input  logic    clk,
    input  logic    rst,
    ula_arb_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state;
    logic [2:0]   op_r;
    logic [W-1:0] a_r, b_r;
    logic         id_r;
    logic         last;
    logic         gnt, gnt_id, ill;
    logic [W-1:0] data_r;
    logic         id_o, cout_r, zero_r, err_r;

    // With both valid, the requester not granted last wins.
    assign gnt    = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    assign gnt_id = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
    assign ill    = &op_r[2:1];

    assign bus.req0_ready = gnt && !gnt_id;
    assign bus.req1_ready = gnt &&  gnt_id;
    assign bus.alu_a      = a_r;
    assign bus.alu_b      = b_r;
    assign bus.alu_sel    = op_r;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.busy       = (state != IDLE);
    assign bus.rsp_id     = id_o;
    assign bus.rsp_data   = data_r;
    assign bus.rsp_cout   = cout_r;
    assign bus.rsp_zero   = zero_r;
    assign bus.rsp_err    = err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            id_r   <= 1'b0;
            last   <= 1'b1;  // requester 0 wins the first contested grant
            data_r <= '0;
            id_o   <= 1'b0;
            cout_r <= 1'b0;
            zero_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt) begin
                    op_r  <= gnt_id ? bus.req1_op : bus.req0_op;
                    a_r   <= gnt_id ? bus.req1_a  : bus.req0_a;
                    b_r   <= gnt_id ? bus.req1_b  : bus.req0_b;
                    id_r  <= gnt_id;
                    last  <= gnt_id;
                    state <= EXEC;
                end
                EXEC: begin
                    // Ops 110/111 still occupy the ALU slot but report an error.
                    data_r <= ill ? '0 : bus.alu_out;
                    cout_r <= (op_r[2:1] == 2'b00) && bus.alu_cout;
                    zero_r <= ill || (bus.alu_out == '0);
                    err_r  <= ill;
                    id_o   <= id_r;
                    state  <= RESP;
                end
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_arb.sv
// Directed bench for ula_arb: vector table of single-requester ops plus
// contention, back-pressure and reset-mid-op sequences. All activity at negedge.
module tb_ula_arb;
    logic clk;
    logic rst;
    int   errs   = 0;
    int   checks = 0;

    ula_arb_if #(.W(8)) bus();
    ula_arb #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU model: add, sub(borrow), and, or, xor, not a; 110/111 give a+b so
    // forcing to zero is observable. cout is 1 for logic ops to expose gating.
    always_comb begin
        bus.alu_out  = 8'h00;
        bus.alu_cout = 1'b1;
        case (bus.alu_sel)
            3'b000: {bus.alu_cout, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b001: {bus.alu_cout, bus.alu_out} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'b010: bus.alu_out = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_out = bus.alu_a | bus.alu_b;
            3'b100: bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'b101: bus.alu_out = ~bus.alu_a;
            default: bus.alu_out = bus.alu_a + bus.alu_b;
        endcase
    end

    typedef struct {
        logic       who;
        logic [2:0] op;
        logic [7:0] a, b, data;
        logic       cout, zero, err;
    } vec_t;

    vec_t vt[10];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic who, input logic v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (who) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Returns at a negedge with rst just released.
    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    int g0, g1, nr, gcnt;
    logic       rid[2];
    logic [7:0] rdat[2];
    logic       gseq[6];
    int         gcyc[6];
    logic       drop0, drop1, both;

    initial begin
        vt[0] = '{1'b0, 3'b000, 8'd5,   8'd3,   8'd8,   1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 3'b000, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 3'b001, 8'd3,   8'd5,   8'd254, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 3'b001, 8'd7,   8'd7,   8'd0,   1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b1, 3'b010, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 3'b011, 8'h0F,  8'hA0,  8'hAF,  1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 3'b100, 8'hFF,  8'hFF,  8'h00,  1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b0, 3'b101, 8'd5,   8'd0,   8'd250, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b1, 3'b110, 8'd7,   8'd9,   8'd0,   1'b0, 1'b1, 1'b1};
        vt[9] = '{1'b0, 3'b111, 8'd1,   8'd1,   8'd0,   1'b0, 1'b1, 1'b1};

        set_req(1'b0, 1'b1, 3'b000, 8'd1, 8'd1);
        set_req(1'b1, 1'b0, 3'b000, 8'd0, 8'd0);
        bus.rsp_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset state, with a request pending that must not see ready.
        @(negedge clk); #1;
        chk1("rst rsp_valid", bus.rsp_valid, 1'b0);
        chk1("rst busy",      bus.busy,      1'b0);
        chk1("rst req0_ready", bus.req0_ready, 1'b0);
        chk1("rst req1_ready", bus.req1_ready, 1'b0);
        chk1("rst rsp_id",    bus.rsp_id,    1'b0);
        chk8("rst rsp_data",  bus.rsp_data,  8'd0);
        chk1("rst rsp_cout",  bus.rsp_cout,  1'b0);
        chk1("rst rsp_zero",  bus.rsp_zero,  1'b0);
        chk1("rst rsp_err",   bus.rsp_err,   1'b0);
        chk8("rst alu_a",     bus.alu_a,     8'd0);
        chk8("rst alu_b",     bus.alu_b,     8'd0);
        chk8("rst alu_sel",   {5'd0, bus.alu_sel}, 8'd0);
        set_req(1'b0, 1'b0, 3'b000, 8'd0, 8'd0);
        @(negedge clk); rst = 1'b0;

        // Vector table: single requester, grant at N, response at N+2.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_req(vt[i].who, 1'b1, vt[i].op, vt[i].a, vt[i].b);
            #1;
            chk1("vec ready granted", vt[i].who ? bus.req1_ready : bus.req0_ready, 1'b1);
            chk1("vec ready other",   vt[i].who ? bus.req0_ready : bus.req1_ready, 1'b0);
            @(negedge clk);
            set_req(vt[i].who, 1'b0, 3'b000, 8'd0, 8'd0);
            #1;
            chk1("vec exec busy",      bus.busy,      1'b1);
            chk1("vec exec rsp_valid", bus.rsp_valid, 1'b0);
            chk8("vec exec alu_a",     bus.alu_a,     vt[i].a);
            @(negedge clk); #1;
            chk1("vec rsp_valid", bus.rsp_valid, 1'b1);
            chk1("vec rsp_id",    bus.rsp_id,    vt[i].who);
            chk8("vec rsp_data",  bus.rsp_data,  vt[i].data);
            chk1("vec rsp_cout",  bus.rsp_cout,  vt[i].cout);
            chk1("vec rsp_zero",  bus.rsp_zero,  vt[i].zero);
            chk1("vec rsp_err",   bus.rsp_err,   vt[i].err);
            @(negedge clk); #1;
            chk1("vec back idle", bus.busy, 1'b0);
        end

        // Contention after reset: req0 first, each granted once.
        set_req(1'b0, 1'b1, 3'b001, 8'd23, 8'd11);
        set_req(1'b1, 1'b1, 3'b101, 8'd5,  8'd0);
        do_reset();
        g0 = 0; g1 = 0; nr = 0; drop0 = 1'b0; drop1 = 1'b0;
        for (int c = 0; c < 20 && nr < 2; c++) begin
            if (drop0) begin bus.req0_valid = 1'b0; drop0 = 1'b0; end
            if (drop1) begin bus.req1_valid = 1'b0; drop1 = 1'b0; end
            #1;
            if (bus.req0_ready) begin g0++; drop0 = 1'b1; end
            if (bus.req1_ready) begin g1++; drop1 = 1'b1; end
            if (bus.rsp_valid) begin rid[nr] = bus.rsp_id; rdat[nr] = bus.rsp_data; nr++; end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chkn("cont responses", nr, 2);
        if (nr == 2) begin
            chk1("cont rsp0 id",   rid[0],  1'b0);
            chk8("cont rsp0 data", rdat[0], 8'd12);
            chk1("cont rsp1 id",   rid[1],  1'b1);
            chk8("cont rsp1 data", rdat[1], 8'd250);
        end
        chkn("cont grants req0", g0, 1);
        chkn("cont grants req1", g1, 1);

        // Sustained contention: alternation and 3-cycle issue interval.
        set_req(1'b0, 1'b1, 3'b000, 8'd1, 8'd2);
        set_req(1'b1, 1'b1, 3'b000, 8'd3, 8'd4);
        do_reset();
        gcnt = 0; both = 1'b0;
        for (int c = 0; c < 40 && gcnt < 6; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both = 1'b1;
            if (bus.req0_ready || bus.req1_ready) begin
                gseq[gcnt] = bus.req1_ready; gcyc[gcnt] = c; gcnt++;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chkn("sust grant count", gcnt, 6);
        chk1("sust two readies", both, 1'b0);
        for (int i = 0; i < gcnt; i++) chk1("sust grant order", gseq[i], (i % 2) == 1);
        if (gcnt >= 2) chkn("sust issue interval", gcyc[1] - gcyc[0], 3);
        repeat (3) @(negedge clk);

        // Back-pressure with req1 pending; last grant was req1, so req0 wins.
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 3'b000, 8'd5, 8'd3);
        set_req(1'b1, 1'b1, 3'b010, 8'hF0, 8'h3C);
        #1 chk1("bp req0_ready", bus.req0_ready, 1'b1);
        @(negedge clk); bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        chk1("bp rsp_valid rise", bus.rsp_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk1("bp hold valid", bus.rsp_valid, 1'b1);
            chk8("bp hold data",  bus.rsp_data,  8'd8);
            chk1("bp hold id",    bus.rsp_id,    1'b0);
            chk1("bp hold busy",  bus.busy,      1'b1);
            chk1("bp no ready1",  bus.req1_ready, 1'b0);
        end
        @(negedge clk); bus.rsp_ready = 1'b1; #1;
        chk1("bp handshake valid",  bus.rsp_valid, 1'b1);
        chk1("bp no grant on hs",   bus.req1_ready, 1'b0);
        @(negedge clk); #1;
        chk1("bp done valid",       bus.rsp_valid, 1'b0);
        chk1("bp req1 granted",     bus.req1_ready, 1'b1);
        @(negedge clk); bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        chk8("bp req1 data", bus.rsp_data, 8'h30);
        chk1("bp req1 id",   bus.rsp_id,   1'b1);
        @(negedge clk);

        // Reset mid-op after a req0 grant; req0 must still win the next contest.
        set_req(1'b0, 1'b1, 3'b000, 8'd1, 8'd1);
        #1 chk1("mid req0_ready", bus.req0_ready, 1'b1);
        @(negedge clk); bus.req0_valid = 1'b0; #1;
        chk1("mid exec busy", bus.busy, 1'b1);
        rst = 1'b1; #1;
        chk1("mid rst rsp_valid", bus.rsp_valid, 1'b0);
        chk1("mid rst busy",      bus.busy,      1'b0);
        chk8("mid rst alu_a",     bus.alu_a,     8'd0);
        chk8("mid rst alu_b",     bus.alu_b,     8'd0);
        chk8("mid rst alu_sel",   {5'd0, bus.alu_sel}, 8'd0);
        set_req(1'b0, 1'b1, 3'b000, 8'd10, 8'd20);
        set_req(1'b1, 1'b1, 3'b100, 8'd1,  8'd3);
        #1;
        chk1("mid rst no ready0", bus.req0_ready, 1'b0);
        chk1("mid rst no ready1", bus.req1_ready, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        chk1("mid post req0 wins", bus.req0_ready, 1'b1);
        chk1("mid post req1 loses", bus.req1_ready, 1'b0);
        @(negedge clk); bus.req0_valid = 1'b0; #1;
        chk1("mid no stale rsp", bus.rsp_valid, 1'b0);
        @(negedge clk); #1;
        chk1("mid new rsp_valid", bus.rsp_valid, 1'b1);
        chk8("mid new rsp_data",  bus.rsp_data,  8'd30);
        @(negedge clk); #1;
        chk1("mid req1 granted", bus.req1_ready, 1'b1);
        @(negedge clk); bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        chk8("mid req1 data", bus.rsp_data, 8'd2);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
